// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_stall_ctrl
//  Purpose  : Stall/flush controller for the 5-stage pipeline: load-use,
//             taken-branch and data-memory wait handling, plus a saturating
//             stall-cycle counter. Optional memory-wait timeout enabled by
//             defining MEM_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_ex_memRead,
    input  logic [4:0]  id_ex_rt,
    input  logic        ex_branch_taken,
    input  logic        ex_mem_memAccess,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        ex_mem_write,
    output logic        mem_wb_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_flush,
    output logic        mem_req,
    output logic        mem_error,
    output logic [1:0]  state,
    output logic [15:0] stall_cycles
);

    localparam logic [1:0] c_st_run      = 2'd0;
    localparam logic [1:0] c_st_mem_wait = 2'd1;
    localparam logic [1:0] c_st_error    = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_stall_cycles;
    logic        r_mem_error;
    logic        w_err_set;
    logic        w_lu;

    assign w_lu = id_ex_memRead && (id_ex_rt != 5'd0) &&
                  ((id_ex_rt == id_rs) || (id_ex_rt == id_rt));

`ifdef MEM_TIMEOUT_EN
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_wait_cnt;
    logic [15:0] w_wait_nxt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT_CYCLES;
`endif

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        mem_req      = 1'b0;
        w_state_nxt  = r_state;
        w_err_set    = 1'b0;
`ifdef MEM_TIMEOUT_EN
        w_wait_nxt   = r_wait_cnt;
`endif
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else begin
            case (r_state)
                c_st_run: begin
                    mem_req = ex_mem_memAccess;
                    if (ex_mem_memAccess && !mem_ready) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                        mem_wb_flush = 1'b1;
                        w_state_nxt  = c_st_mem_wait;
`ifdef MEM_TIMEOUT_EN
                        w_wait_nxt   = 16'd0;
`endif
                    end else begin
                        if (w_lu) begin
                            pc_write    = 1'b0;
                            if_id_write = 1'b0;
                            id_ex_flush = 1'b1;
                        end
                        // A taken branch overrides the load-use PC hold so the target loads.
                        if (ex_branch_taken) begin
                            pc_write    = 1'b1;
                            if_id_flush = 1'b1;
                            id_ex_flush = 1'b1;
                        end
                    end
                end
                c_st_mem_wait: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        w_state_nxt = c_st_run;
                    end else begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                        mem_wb_flush = 1'b1;
`ifdef MEM_TIMEOUT_EN
                        if (r_wait_cnt == c_timeout_last) begin
                            w_state_nxt = c_st_error;
                            w_err_set   = 1'b1;
                        end else begin
                            w_wait_nxt  = r_wait_cnt + 16'd1;
                        end
`endif
                    end
                end
                default: begin
                    // ERROR holds every stage until reset.
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    mem_wb_write = 1'b0;
                    w_state_nxt  = c_st_error;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_st_run;
            r_stall_cycles <= 16'd0;
            r_mem_error    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_err_set) begin
                r_mem_error <= 1'b1;
            end
            if (!pc_write && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= 16'd0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
        end
    end
    assign mem_error = r_mem_error;
`else
    logic w_unused_err;
    assign w_unused_err = r_mem_error | w_err_set;
    assign mem_error    = 1'b0;
`endif

    assign state        = r_state;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_stall_ctrl
//  Purpose  : Scoreboard bench for pipeline_stall_ctrl with a rule-level
//             reference model; directed scenarios followed by random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam int c_to    = 4;
    localparam bit c_to_en = 1'b1;
`else
    localparam int c_to    = 256;
    localparam bit c_to_en = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, id_ex_rt;
    logic        id_ex_memRead, ex_branch_taken, ex_mem_memAccess, mem_ready;
    logic        pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic        if_id_flush, id_ex_flush, mem_wb_flush;
    logic        mem_req, mem_error;
    logic [1:0]  state;
    logic [15:0] stall_cycles;

    pipeline_stall_ctrl #(.TIMEOUT_CYCLES(c_to)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_ex_memRead(id_ex_memRead), .id_ex_rt(id_ex_rt),
        .ex_branch_taken(ex_branch_taken), .ex_mem_memAccess(ex_mem_memAccess),
        .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
        .mem_req(mem_req), .mem_error(mem_error),
        .state(state), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  we;   // pc, if_id, id_ex, ex_mem, mem_wb
        logic [2:0]  fl;   // if_id, id_ex, mem_wb
        logic        req;
        logic        err;
        logic [1:0]  st;
        logic [15:0] sc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: mode 0=running, 1=waiting on memory, 2=timed out
    int m_mode  = 0;
    int m_stall = 0;
    int m_wait  = 0;
    bit m_err   = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input logic [4:0] rs, input logic [4:0] rt,
                        input bit mr, input logic [4:0] mrt, input bit br,
                        input bit ma, input bit rdy);
        exp_t e;
        bit   lu;
        reset = rst; id_rs = rs; id_rt = rt; id_ex_memRead = mr; id_ex_rt = mrt;
        ex_branch_taken = br; ex_mem_memAccess = ma; mem_ready = rdy;
        lu   = mr && (mrt != 0) && (mrt == rs || mrt == rt);
        e.st = 2'(m_mode); e.sc = 16'(m_stall); e.err = m_err;
        if (rst) begin
            e.we = 5'b00000; e.fl = 3'b111; e.req = 1'b0;
        end else if (m_mode == 0) begin
            e.req = ma;
            if (ma && !rdy) begin
                e.we = 5'b00001; e.fl = 3'b001;
            end else begin
                e.we = 5'b11111; e.fl = 3'b000;
                if (lu) begin e.we[4] = 1'b0; e.we[3] = 1'b0; e.fl[1] = 1'b1; end
                if (br) begin e.we[4] = 1'b1; e.fl[2] = 1'b1; e.fl[1] = 1'b1; end
            end
        end else if (m_mode == 1) begin
            e.req = 1'b1;
            if (rdy) begin e.we = 5'b11111; e.fl = 3'b000; end
            else     begin e.we = 5'b00001; e.fl = 3'b001; end
        end else begin
            e.we = 5'b00000; e.fl = 3'b000; e.req = 1'b0;
        end
        sb.push_back(e);
        // advance the model to what should hold after this edge
        if (rst) begin
            m_mode = 0; m_stall = 0; m_wait = 0; m_err = 1'b0;
        end else begin
            if (!e.we[4] && m_stall < 65535) m_stall++;
            if (m_mode == 0 && ma && !rdy) begin
                m_mode = 1; m_wait = 0;
            end else if (m_mode == 1) begin
                if (rdy) m_mode = 0;
                else if (c_to_en && m_wait == c_to - 1) begin m_mode = 2; m_err = 1'b1; end
                else m_wait++;
            end
        end
        @(posedge clk); #1;
    endtask

    // Monitor: outputs are valid every cycle, so compare each pushed expectation mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("enables", 16'({pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write}), 16'(e.we));
                chk("flushes", 16'({if_id_flush, id_ex_flush, mem_wb_flush}), 16'(e.fl));
                chk("mem_req", 16'(mem_req), 16'(e.req));
                chk("mem_error", 16'(mem_error), 16'(e.err));
                chk("state", 16'(state), 16'(e.st));
                chk("stall_cycles", stall_cycles, e.sc);
            end
        end
    end

    initial begin
        reset = 1'b1; id_rs = 0; id_rt = 0; id_ex_memRead = 0; id_ex_rt = 0;
        ex_branch_taken = 0; ex_mem_memAccess = 0; mem_ready = 0;
        @(posedge clk); #1;
        // reset and idle
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step(0, 1, 2, 0, 0, 0, 0, 0);
        // load-use, then the r0 case
        step(0, 5, 3, 1, 5, 0, 0, 0);
        step(0, 5, 3, 0, 0, 0, 0, 0);
        step(0, 0, 3, 1, 0, 0, 0, 0);
        step(0, 4, 5, 1, 5, 1, 1, 1);   // load-use with branch, memory done same cycle
        // taken branch
        step(0, 1, 2, 0, 0, 1, 0, 0);
        step(0, 1, 2, 0, 0, 0, 1, 1);
        // memory wait with a branch during the wait
        step(0, 1, 2, 0, 0, 0, 1, 0);
        step(0, 1, 2, 0, 0, 1, 1, 0);
        step(0, 1, 2, 0, 0, 1, 1, 0);
        step(0, 1, 2, 0, 0, 1, 1, 1);
        step(0, 1, 2, 0, 0, 1, 0, 0);
`ifdef MEM_TIMEOUT_EN
        repeat (7) step(0, 1, 2, 0, 0, 0, 1, 0);
        step(0, 1, 2, 0, 0, 0, 1, 1);
        step(1, 1, 2, 0, 0, 0, 1, 0);
        step(0, 1, 2, 0, 0, 0, 0, 0);
`endif
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 40), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 50));
        end
        // saturation through a continuous load-use hold
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 70000; i++) step(0, 7, 1, 1, 7, 0, 0, 0);
        chk("stall_saturated", stall_cycles, 16'hFFFF);
        step(0, 1, 2, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
